mips_run_ctrl: RTL

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_run_ctrl_if.sv | 25 ++
 rtl/mips_run_ctrl.sv | 92 +++++++++
 2 files changed

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - run-control signal bundle between debug front panel and core
`timescale 1ns/1ps
interface mips_run_ctrl_if #(
   parameter int PC_W = 32
);
   logic            run_sw;
   logic            step_pb;
   logic            bp_en;
   logic [PC_W-1:0] bp_addr;
   logic [PC_W-1:0] pc_current;
   logic            cpu_ce;
   logic [1:0]      run_state;
   logic            bp_hit;
   logic [31:0]     cycle_count;

   modport master (
      output run_sw, step_pb, bp_en, bp_addr, pc_current,
      input  cpu_ce, run_state, bp_hit, cycle_count
   );

   modport slave (
      input  run_sw, step_pb, bp_en, bp_addr, pc_current,
      output cpu_ce, run_state, bp_hit, cycle_count
   );
endinterface

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - halt/run/step/breakpoint clock-enable controller for a MIPS core
// Define RUN_CTRL_CYCLE_CNT_EN to implement the cpu_ce pulse counter; otherwise cycle_count reads 0.
`timescale 1ns/1ps
module mips_run_ctrl #(
   parameter int TICK_DIV = 20000,
   parameter int PC_W     = 32
) (
   input  logic            clk,
   input  logic            rst,
   mips_run_ctrl_if.slave  bus
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      HALT  = 2'b00,
      RUN   = 2'b01,
      STEP  = 2'b10,
      BREAK = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] tick_cnt_q;
   logic          step_prev_q;
   logic          run_prev_q;
   logic          tick;
   logic          step_edge;
   logic          run_rise;
   logic          bp_match;
   logic          ce_c;

   assign tick      = (tick_cnt_q == CW'(TICK_DIV - 1));
   assign step_edge = bus.step_pb & ~step_prev_q;
   assign run_rise  = bus.run_sw & ~run_prev_q;
   assign bp_match  = bus.bp_en & (bus.pc_current[PC_W-1:0] == bus.bp_addr[PC_W-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HALT;
         tick_cnt_q  <= '0;
         step_prev_q <= 1'b0;
         run_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
         step_prev_q <= bus.step_pb;
         run_prev_q  <= bus.run_sw;
      end
   end

   // cpu_ce is decoded from the registered state, so reset clears it without waiting for a clock.
   always_comb begin
      state_d = state_q;
      ce_c    = 1'b0;
      case (state_q)
         HALT: begin
            if (bus.run_sw || run_rise) state_d = RUN;
            else if (step_edge)         state_d = STEP;
         end
         RUN: begin
            if (!bus.run_sw)            state_d = HALT;
            else if (tick && bp_match)  state_d = BREAK;
            else                        ce_c    = tick;
         end
         STEP: begin
            ce_c    = 1'b1;
            state_d = HALT;
         end
         BREAK: begin
            if (step_edge)              state_d = STEP;
            else if (!bus.run_sw)       state_d = HALT;
         end
         default:                       state_d = HALT;
      endcase
   end

   assign bus.cpu_ce    = ce_c;
   assign bus.run_state = state_q;
   assign bus.bp_hit    = (state_q == BREAK);

`ifdef RUN_CTRL_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cycle_cnt_q <= 32'h0;
      else if (ce_c) cycle_cnt_q <= cycle_cnt_q + 32'd1;
   end

   assign bus.cycle_count = cycle_cnt_q;
`else
   assign bus.cycle_count = 32'h0;
`endif
endmodule
